// File: rtl/mfda_switch_sequencer.sv
// mfda_switch_sequencer
// Break-before-make sequencer for the valve-open lines of the planar chip's
// flow switches (flow_switch3 and flow_switch4 alike, four port lines each).
// One route command is taken at a time. The target switch's open ports are
// closed, a close interval elapses, the new ports open, and a settle interval
// elapses before completion is pulsed. Ports of other switches never move.
module mfda_switch_sequencer #(
    parameter int NUM_SW     = 22,
    parameter int SW_W       = 5,
    parameter int CLOSE_CYC  = 8,
    parameter int SETTLE_CYC = 16,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [SW_W-1:0]       cmd_sw,
    input  logic [3:0]            cmd_mask,
    input  logic                  all_close,
    output logic [NUM_SW*4-1:0]   valve_open,
    output logic                  busy,
    output logic                  done_pulse,
    output logic                  err_pulse
);

    localparam int VW = NUM_SW * 4;

    // Interval counters are loaded with N-1 so that the transition happens on
    // the N-th edge after the load.
    localparam logic [CNT_W-1:0] CLOSE_LOAD  = CNT_W'(CLOSE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CLOSE_WAIT = 2'd1,
        ST_SETTLE     = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Helpers for addressing one switch's 4-bit field in the flat vector
    // ------------------------------------------------------------------

    // Current port mask of switch sw (zero for ids beyond the vector).
    function automatic logic [3:0] get_sw_mask(input logic [VW-1:0] vec,
                                               input logic [SW_W-1:0] sw);
        logic [VW-1:0] shifted;
        shifted = vec >> {sw, 2'b00};
        return shifted[3:0];
    endfunction

    // Vector with switch sw's field replaced by m; all other bits kept.
    function automatic logic [VW-1:0] put_sw_mask(input logic [VW-1:0] vec,
                                                  input logic [SW_W-1:0] sw,
                                                  input logic [3:0] m);
        logic [VW-1:0] field;
        logic [VW-1:0] value;
        field = {{(VW-4){1'b0}}, 4'hF} << {sw, 2'b00};
        value = {{(VW-4){1'b0}}, m} << {sw, 2'b00};
        return (vec & ~field) | value;
    endfunction

    // A single open port cannot form a route.
    function automatic logic is_single_port(input logic [3:0] m);
        return (m != 4'b0000) && ((m & (m - 4'b0001)) == 4'b0000);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [SW_W-1:0]   sw_r;
    logic [3:0]        mask_r;
    logic [VW-1:0]     valve_r;
    logic              done_r;
    logic              err_r;

    logic              cmd_ready_s;
    logic              accept_s;
    logic              sw_ok_s;
    logic              reject_s;
    logic              noop_s;
    logic [3:0]        cur_mask_s;

    assign cmd_ready_s = (state_r == ST_IDLE) & ~rst & ~all_close;
    assign cmd_ready   = cmd_ready_s;
    assign valve_open  = valve_r;
    assign busy        = (state_r != ST_IDLE);
    assign done_pulse  = done_r;
    assign err_pulse   = err_r;

    // Classify the offered command against the switch's present mask.
    always_comb begin
        cur_mask_s = get_sw_mask(valve_r, cmd_sw);
        accept_s   = cmd_valid & cmd_ready_s;
        sw_ok_s    = (32'(cmd_sw) < 32'(NUM_SW));
        reject_s   = ~sw_ok_s | is_single_port(cmd_mask);
        if (sw_ok_s) begin
            noop_s = (cmd_mask == cur_mask_s);
        end else begin
            noop_s = 1'b0;
        end
    end

    // Sequencer FSM: reset, emergency close, then close/settle sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            sw_r    <= {SW_W{1'b0}};
            mask_r  <= 4'b0000;
            valve_r <= {VW{1'b0}};
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else if (all_close) begin
            // Emergency close abandons any command silently.
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            valve_r <= {VW{1'b0}};
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (reject_s) begin
                            err_r <= 1'b1;
                        end else if (noop_s) begin
                            done_r <= 1'b1;
                        end else if (cur_mask_s != 4'b0000) begin
                            // Break first: close the switch's open ports.
                            sw_r    <= cmd_sw;
                            mask_r  <= cmd_mask;
                            valve_r <= put_sw_mask(valve_r, cmd_sw, 4'b0000);
                            cnt_r   <= CLOSE_LOAD;
                            state_r <= ST_CLOSE_WAIT;
                        end else begin
                            // Nothing open: make immediately, then settle.
                            sw_r    <= cmd_sw;
                            mask_r  <= cmd_mask;
                            valve_r <= put_sw_mask(valve_r, cmd_sw, cmd_mask);
                            cnt_r   <= SETTLE_LOAD;
                            state_r <= ST_SETTLE;
                        end
                    end
                end
                ST_CLOSE_WAIT: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        if (mask_r != 4'b0000) begin
                            valve_r <= put_sw_mask(valve_r, sw_r, mask_r);
                            cnt_r   <= SETTLE_LOAD;
                            state_r <= ST_SETTLE;
                        end else begin
                            // Close-only command finishes after the close interval.
                            state_r <= ST_IDLE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_SETTLE: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    // Unreachable encoding: fail safe with every valve closed.
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    valve_r <= {VW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mfda_switch_sequencer.sv
// Testbench for mfda_switch_sequencer. The reference model tracks each
// switch's port mask and, for the command in flight, the absolute cycle at
// which the new ports open and the cycle at which completion is due.
module tb_mfda_switch_sequencer;

    localparam int NUM_SW     = 22;
    localparam int SW_W       = 5;
    localparam int CLOSE_CYC  = 8;
    localparam int SETTLE_CYC = 16;
    localparam int CNT_W      = 8;
    localparam int VW         = NUM_SW * 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [SW_W-1:0] cmd_sw = '0;
    logic [3:0]      cmd_mask = 4'b0000;
    logic            all_close = 1'b0;
    logic [VW-1:0]   valve_open;
    logic            busy;
    logic            done_pulse;
    logic            err_pulse;
    logic [VW+2:0]   dut_obs;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model state
    logic [3:0] m_valves [NUM_SW];
    logic       m_active = 1'b0;
    logic       m_done   = 1'b0;
    logic       m_err    = 1'b0;
    int         m_sw     = 0;
    logic [3:0] m_mask   = 4'b0000;
    int         m_open_at = -1;
    int         m_done_at = -1;

    mfda_switch_sequencer #(
        .NUM_SW(NUM_SW), .SW_W(SW_W), .CLOSE_CYC(CLOSE_CYC),
        .SETTLE_CYC(SETTLE_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_sw(cmd_sw), .cmd_mask(cmd_mask), .all_close(all_close),
        .valve_open(valve_open), .busy(busy), .done_pulse(done_pulse),
        .err_pulse(err_pulse)
    );

    assign dut_obs = {valve_open, busy, done_pulse, err_pulse};

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] model_flat();
        logic [VW-1:0] f;
        f = '0;
        for (int s = 0; s < NUM_SW; s++) f[4*s +: 4] = m_valves[s];
        return f;
    endfunction

    function automatic logic [VW+2:0] model_obs();
        return {model_flat(), m_active, m_done, m_err};
    endfunction

    function automatic logic model_ready();
        return !m_active && !rst && !all_close;
    endfunction

    function automatic int popcount4(input logic [3:0] m);
        return int'(m[0]) + int'(m[1]) + int'(m[2]) + int'(m[3]);
    endfunction

    // Advance the model by the edge about to happen, using the driven inputs.
    task automatic model_step();
        int n;
        logic [3:0] old;
        n = cyc + 1;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (rst || all_close) begin
            for (int s = 0; s < NUM_SW; s++) m_valves[s] = 4'b0000;
            m_active = 1'b0;
        end else if (m_active) begin
            if (n == m_open_at) m_valves[m_sw] = m_mask;
            if (n == m_done_at) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end else if (cmd_valid) begin
            if (int'(cmd_sw) >= NUM_SW || popcount4(cmd_mask) == 1) begin
                m_err = 1'b1;
            end else begin
                old = m_valves[int'(cmd_sw)];
                if (old == cmd_mask) begin
                    m_done = 1'b1;
                end else begin
                    m_active = 1'b1;
                    m_sw     = int'(cmd_sw);
                    m_mask   = cmd_mask;
                    if (old != 4'b0000) begin
                        m_valves[m_sw] = 4'b0000;
                        m_open_at = n + CLOSE_CYC;
                        m_done_at = n + CLOSE_CYC + ((cmd_mask != 4'b0000) ? SETTLE_CYC : 0);
                    end else begin
                        m_valves[m_sw] = cmd_mask;
                        m_open_at = n;
                        m_done_at = n + SETTLE_CYC;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [SW_W-1:0] sw, input logic [3:0] m);
        cmd_valid = 1'b1;
        cmd_sw    = sw;
        cmd_mask  = m;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        for (int s = 0; s < NUM_SW; s++) m_valves[s] = 4'b0000;
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (dut_obs !== {(VW+3){1'b0}}) $display("FAIL reset_outputs: got %h expected 0", dut_obs);
        else n_pass++;
        n_checks++;
        if (cmd_ready !== 1'b0) $display("FAIL reset_ready_low: got %b expected 0", cmd_ready);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", cmd_ready);
        else n_pass++;
    endtask

    task automatic test_open_from_closed();
        logic [VW-1:0] exp_v;
        send(5'd3, 4'b1010);
        exp_v = '0;
        exp_v[15:12] = 4'b1010;
        n_checks++;
        if (valve_open !== exp_v) $display("FAIL open_sw3: got %h expected %h", valve_open, exp_v);
        else n_pass++;
        for (int k = 1; k <= SETTLE_CYC; k++) begin
            tick();
            n_checks++;
            if (done_pulse !== (k == SETTLE_CYC)) $display("FAIL open_done_timing k=%0d: got %b expected %b", k, done_pulse, (k == SETTLE_CYC));
            else n_pass++;
            n_checks++;
            if (dut_obs !== model_obs()) $display("FAIL open_model k=%0d: got %h expected %h", k, dut_obs, model_obs());
            else n_pass++;
        end
    endtask

    task automatic test_reroute();
        logic [3:0] exp_b;
        send(5'd3, 4'b0101);
        n_checks++;
        if (valve_open[15:12] !== 4'b0000 || cmd_ready !== 1'b0) $display("FAIL reroute_break: got bits %b ready %b expected 0000 0", valve_open[15:12], cmd_ready);
        else n_pass++;
        for (int k = 1; k <= CLOSE_CYC + SETTLE_CYC; k++) begin
            tick();
            exp_b = (k >= CLOSE_CYC) ? 4'b0101 : 4'b0000;
            n_checks++;
            if (valve_open[15:12] !== exp_b) $display("FAIL reroute_bits k=%0d: got %b expected %b", k, valve_open[15:12], exp_b);
            else n_pass++;
            n_checks++;
            if (cmd_ready !== (k == CLOSE_CYC + SETTLE_CYC)) $display("FAIL reroute_ready k=%0d: got %b expected %b", k, cmd_ready, (k == CLOSE_CYC + SETTLE_CYC));
            else n_pass++;
            n_checks++;
            if (dut_obs !== model_obs()) $display("FAIL reroute_model k=%0d: got %h expected %h", k, dut_obs, model_obs());
            else n_pass++;
        end
    endtask

    task automatic test_reject();
        logic [SW_W-1:0] rs [2];
        logic [3:0]      rm [2];
        logic [VW-1:0]   prev;
        rs[0] = 5'd22; rm[0] = 4'b1100;
        rs[1] = 5'd0;  rm[1] = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            prev = valve_open;
            send(rs[i], rm[i]);
            n_checks++;
            if (err_pulse !== 1'b1 || busy !== 1'b0 || done_pulse !== 1'b0) $display("FAIL reject_pulse %0d: got err %b busy %b done %b expected 1 0 0", i, err_pulse, busy, done_pulse);
            else n_pass++;
            n_checks++;
            if (valve_open !== prev) $display("FAIL reject_valves %0d: got %h expected %h", i, valve_open, prev);
            else n_pass++;
            tick();
            n_checks++;
            if (err_pulse !== 1'b0 || busy !== 1'b0) $display("FAIL reject_after %0d: got err %b busy %b expected 0 0", i, err_pulse, busy);
            else n_pass++;
        end
    endtask

    task automatic test_noop_and_close();
        logic [VW-1:0] prev;
        prev = valve_open;
        send(5'd3, 4'b0101);
        n_checks++;
        if (done_pulse !== 1'b1 || busy !== 1'b0 || valve_open !== prev) $display("FAIL noop: got done %b busy %b valves %h expected 1 0 %h", done_pulse, busy, valve_open, prev);
        else n_pass++;
        tick();
        send(5'd3, 4'b0000);
        n_checks++;
        if (valve_open[15:12] !== 4'b0000 || busy !== 1'b1) $display("FAIL close_only_start: got bits %b busy %b expected 0000 1", valve_open[15:12], busy);
        else n_pass++;
        for (int k = 1; k <= CLOSE_CYC; k++) begin
            tick();
            n_checks++;
            if (done_pulse !== (k == CLOSE_CYC)) $display("FAIL close_only_done k=%0d: got %b expected %b", k, done_pulse, (k == CLOSE_CYC));
            else n_pass++;
            n_checks++;
            if (dut_obs !== model_obs()) $display("FAIL close_only_model k=%0d: got %h expected %h", k, dut_obs, model_obs());
            else n_pass++;
        end
    endtask

    task automatic test_all_close();
        bit seen;
        send(5'd7, 4'b1100);
        repeat (5) tick();
        all_close = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b0) $display("FAIL all_close_ready: got %b expected 0", cmd_ready);
        else n_pass++;
        tick();
        all_close = 1'b0;
        n_checks++;
        if (dut_obs !== {(VW+3){1'b0}}) $display("FAIL all_close_outputs: got %h expected 0", dut_obs);
        else n_pass++;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_checks++;
            if (dut_obs !== model_obs() || done_pulse !== 1'b0) $display("FAIL all_close_quiet k=%0d: got %h expected %h", k, dut_obs, model_obs());
            else n_pass++;
        end
        send(5'd7, 4'b0011);
        n_checks++;
        if (busy !== 1'b1 || valve_open[31:28] !== 4'b0011) $display("FAIL after_all_close_accept: got busy %b bits %b expected 1 0011", busy, valve_open[31:28]);
        else n_pass++;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            if (done_pulse === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) $display("FAIL after_all_close_done: got no done_pulse expected one within 40 cycles");
        else n_pass++;
    endtask

    task automatic test_rst_mid();
        send(5'd7, 4'b1001);
        n_checks++;
        if (valve_open[31:28] !== 4'b0000 || busy !== 1'b1) $display("FAIL rst_mid_break: got bits %b busy %b expected 0000 1", valve_open[31:28], busy);
        else n_pass++;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b0) $display("FAIL rst_mid_ready: got %b expected 0", cmd_ready);
        else n_pass++;
        tick();
        rst = 1'b0;
        n_checks++;
        if (dut_obs !== {(VW+3){1'b0}}) $display("FAIL rst_mid_outputs: got %h expected 0", dut_obs);
        else n_pass++;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL rst_mid_ready_after: got %b expected 1", cmd_ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit seen;
        int at;
        cmd_valid = 1'b1;
        cmd_sw    = 5'd5;
        cmd_mask  = 4'b0110;
        tick();
        cmd_sw    = 5'd9;
        cmd_mask  = 4'b1111;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL b2b_first_accept: got busy %b expected 1", busy);
        else n_pass++;
        seen = 1'b0;
        at = 0;
        for (int k = 1; k <= 60 && !seen; k++) begin
            tick();
            if (done_pulse === 1'b1) begin
                seen = 1'b1;
                at = k;
            end
        end
        n_checks++;
        if (!seen || at != SETTLE_CYC) $display("FAIL b2b_first_done: got done at %0d expected %0d", at, SETTLE_CYC);
        else n_pass++;
        n_checks++;
        if (cmd_ready !== 1'b1 || dut_obs !== model_obs()) $display("FAIL b2b_done_cycle: got ready %b obs %h expected 1 %h", cmd_ready, dut_obs, model_obs());
        else n_pass++;
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || valve_open[39:36] !== 4'b1111 || valve_open[23:20] !== 4'b0110) $display("FAIL b2b_second_accept: got busy %b sw9 %b sw5 %b expected 1 1111 0110", busy, valve_open[39:36], valve_open[23:20]);
        else n_pass++;
        for (int k = 0; k < 40 && busy === 1'b1; k++) tick();
        n_checks++;
        if (busy !== 1'b0 || dut_obs !== model_obs()) $display("FAIL b2b_drain: got %h expected %h", dut_obs, model_obs());
        else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0] pick [4];
        int r;
        pick[0] = 4'b0011; pick[1] = 4'b1100; pick[2] = 4'b0000; pick[3] = 4'b1111;
        for (int k = 0; k < 600; k++) begin
            rst       = ($urandom_range(0, 249) == 0);
            all_close = ($urandom_range(0, 79) == 0);
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_sw    = ($urandom_range(0, 7) == 0) ? SW_W'($urandom_range(20, 31)) : SW_W'($urandom_range(0, 4));
            r = $urandom_range(0, 9);
            cmd_mask  = (r < 5) ? 4'($urandom_range(0, 15)) : pick[r % 4];
            #1;
            n_checks++;
            if (cmd_ready !== model_ready()) $display("FAIL rand_ready k=%0d: got %b expected %b", k, cmd_ready, model_ready());
            else n_pass++;
            tick();
            n_checks++;
            if (dut_obs !== model_obs()) $display("FAIL rand_model k=%0d: got %h expected %h", k, dut_obs, model_obs());
            else n_pass++;
        end
        rst = 1'b0;
        all_close = 1'b0;
        cmd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_open_from_closed();
        test_reroute();
        test_reject();
        test_noop_and_close();
        test_all_close();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
